// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_fetch_unit                                          |
// | Description : Instruction-fetch stage. Owns the PC, drives the       |
// |               zero-latency instruction memory and holds the fetched  |
// |               instruction in an IF/ID register with valid/ready.     |
// |               Handles stalls, redirects and address faults.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 128,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  logic [1:0]  state_q,       state_d;
  logic [31:0] pc_q,          pc_d;
  logic        if_valid_q,    if_valid_d;
  logic [31:0] if_pc_q,       if_pc_d;
  logic [31:0] if_instr_q,    if_instr_d;
  logic        fault_q,       fault_d;
  logic [31:0] fault_pc_q,    fault_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        load;
  logic        pc_out_of_range;
  logic        redirect_misaligned;

  // Memory interface depends only on state and PC, never on stall/ready.
  assign imem_en     = (state_q == RUN);
  assign imem_addr   = {2'b00, pc_q[31:2]};
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = fetch_count_q;

  assign load                = !stall && (!if_valid_q || if_ready);
  assign pc_out_of_range     = (pc_q[31:2] >= DEPTH_W);
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  // Next-state logic: redirect beats fault detection beats fetch beats drain.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          pc_d       = redirect_pc;
          if (redirect_misaligned) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
          end
        end else if (load && pc_out_of_range) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end else if (load) begin
          if_instr_d    = imem_instr;
          if_pc_d       = pc_q;
          if_valid_d    = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_count_d = fetch_count_q + 32'd1;
        end else if (if_valid_q && if_ready) begin
          // Decode took the instruction while fetch is stalled.
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end
      end

      FAULT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (redirect_misaligned) begin
            fault_pc_d = redirect_pc;
          end else begin
            fault_d = 1'b0;
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0;
      if_instr_q    <= NOP_INSTR;
      fault_q       <= 1'b0;
      fault_pc_q    <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_if_fetch_unit                                       |
// | Description : Directed self-checking bench for if_fetch_unit with a  |
// |               behavioural instruction memory and expected-output     |
// |               queue of {pc, instr} for each consumed instruction.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [128];
  int          n_assert = 0;
  int          n_fail   = 0;

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(128),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-latency memory model; out-of-range words return a marker value.
  always_comb begin
    imem_instr = 32'hBAD0_0000;
    if (imem_addr < 32'd128) imem_instr = mem[imem_addr[6:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[8:2]];
    sb.push_back(e);
  endtask

  // Compare at the falling edge any instruction decode takes on the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (if_valid && if_ready && !redirect_valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_pc", if_pc, e.pc);
        check("out_instr", if_instr, e.instr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit done;
    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;

    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
    #12;
    check("rst_if_valid", {31'h0, if_valid}, 32'd0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_imem_en", {31'h0, imem_en}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Streaming fetch of A,B,C,D
    check("boot_imem_en", {31'h0, imem_en}, 32'd0);
    push(32'd0); push(32'd4); push(32'd8); push(32'd12);
    tick();
    check("run_imem_en", {31'h0, imem_en}, 32'd1);
    check("run_first_valid", {31'h0, if_valid}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("stream_count", fetch_count, 32'd4);
    stall = 1'b1;
    tick();
    check("drain_valid", {31'h0, if_valid}, 32'd0);
    check("drain_nop", if_instr, NOP);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure with B held
    stall = 1'b0; if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd4;
    tick();
    redirect_valid = 1'b0;
    push(32'd4);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("hold_pc", if_pc, 32'd4);
      check("hold_instr", if_instr, mem[1]);
      check("hold_addr", imem_addr, 32'd2);
      tick();
    end
    check("hold_valid", {31'h0, if_valid}, 32'd1);
    if_ready = 1'b1;
    push(32'd8); push(32'd12);
    tick(); tick();
    stall = 1'b1;
    tick();
    check("bp_sb_empty", 32'(sb.size()), 32'd0);
    check("bp_count", fetch_count, 32'd7);

    // Redirect together with stall flushes a held instruction
    stall = 1'b0; if_ready = 1'b0;
    tick();
    check("pre_redir_valid", {31'h0, if_valid}, 32'd1);
    stall = 1'b1; if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    check("redir_flush", {31'h0, if_valid}, 32'd0);
    check("redir_nop", if_instr, NOP);
    check("redir_addr", imem_addr, 32'h10);
    redirect_valid = 1'b0; stall = 1'b0;
    push(32'h40);
    tick();
    stall = 1'b1;
    tick();
    check("redir_count", fetch_count, 32'd9);

    // Misaligned redirect faults; aligned redirect recovers
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check("mis_fault", {31'h0, fault}, 32'd1);
    check("mis_fault_pc", fault_pc, 32'h42);
    check("mis_imem_en", {31'h0, imem_en}, 32'd0);
    stall = 1'b0;
    tick(); tick();
    check("mis_sticky", {31'h0, fault}, 32'd1);
    check("mis_no_valid", {31'h0, if_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect_valid = 1'b0;
    check("rec_fault", {31'h0, fault}, 32'd0);
    check("rec_fault_pc_held", fault_pc, 32'h42);
    push(32'h8);
    tick();
    check("rec_instr", if_instr, mem[2]);
    stall = 1'b1;
    tick();
    check("rec_count", fetch_count, 32'd10);

    // Asynchronous reset while an instruction is held
    stall = 1'b0; if_ready = 1'b0;
    tick();
    check("pre_rst_valid", {31'h0, if_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", {31'h0, if_valid}, 32'd0);
    check("arst_pc", if_pc, 32'd0);
    check("arst_instr", if_instr, NOP);
    check("arst_fault_pc", fault_pc, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    check("arst_imem_en", {31'h0, imem_en}, 32'd0);
    check("arst_addr", imem_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; if_ready = 1'b1;

    // Sequential fetch from RESET_PC to the end of memory
    for (int i = 0; i < 128; i++) push(32'(i) * 32'd4);
    tick();
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (fault) done = 1'b1;
    end
    check("range_fault_seen", {31'h0, done}, 32'd1);
    check("range_fault_pc", fault_pc, 32'h200);
    check("range_valid", {31'h0, if_valid}, 32'd0);
    check("range_count", fetch_count, 32'd128);
    check("range_imem_en", {31'h0, imem_en}, 32'd0);
    check("range_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
